// File: rtl/legv8_control_unit_if.sv
// Bundle between the LEGv8 control unit, its instruction ROM and the datapath.
// The control unit takes the master side and the ROM/datapath take the slave side.
interface legv8_control_unit_if #(
  parameter int PC_WIDTH = 32
);
  logic [31:0]         instruction;
  logic [3:0]          status;
  logic [PC_WIDTH-1:0] pc;
  logic [31:0]         control_word;
  logic [63:0]         constant;
  logic                halted;

  modport master (
    input  instruction, status,
    output pc, control_word, constant, halted
  );

  modport slave (
    output instruction, status,
    input  pc, control_word, constant, halted
  );
endinterface

// File: rtl/legv8_control_unit.sv
// Multicycle LEGv8 control unit: fetches from a combinational ROM, decodes into the
// datapath control word and constant, and resolves CBZ/B against the status flags.
module legv8_control_unit #(
  parameter int                PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  legv8_control_unit_if.master  bus
);

  typedef enum logic [1:0] {FETCH, EXEC, BRANCH, HALT} state_t;

  typedef struct packed {
    logic       rsvd;
    logic       en_mem;
    logic       en_b;
    logic [1:0] size;
    logic       mem_cs;
    logic       mw;
    logic       en_alu;
    logic       addr_en;
    logic       sl;
    logic [4:0] fs;
    logic       bs;
    logic       rw;
    logic [4:0] sb;
    logic [4:0] sa;
    logic [4:0] da;
  } cw_t;

  localparam logic [4:0]  FS_AND  = 5'b00000;
  localparam logic [4:0]  FS_ORR  = 5'b00100;
  localparam logic [4:0]  FS_ADD  = 5'b01000;
  localparam logic [4:0]  FS_SUB  = 5'b01001;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [5:0]  OP_B    = 6'b000101;

  // Word offsets become byte offsets, sign-extended to the PC width; PC adds wrap.
  function automatic logic signed [PC_WIDTH-1:0] off_imm26(input logic [25:0] imm);
    logic signed [27:0] w;
    w = signed'({imm, 2'b00});
    return PC_WIDTH'(w);
  endfunction

  function automatic logic signed [PC_WIDTH-1:0] off_imm19(input logic [18:0] imm);
    logic signed [20:0] w;
    w = signed'({imm, 2'b00});
    return PC_WIDTH'(w);
  endfunction

  function automatic logic signed [63:0] sext_d9(input logic [8:0] imm);
    logic signed [8:0] s;
    s = signed'(imm);
    return 64'(s);
  endfunction

  state_t              state, state_nxt;
  logic [31:0]         ir, ir_nxt;
  logic [PC_WIDTH-1:0] pc_q, pc_nxt, pc_inc;
  cw_t                 cw;
  logic [63:0]         cst;
  logic                halted;
  logic [2:0]          unused_flags;

  logic [10:0] op11;
  logic [9:0]  op10;
  logic [7:0]  op8;
  logic [5:0]  op6;
  logic [4:0]  rd, rn, rm;

  assign op11   = ir[31:21];
  assign op10   = ir[31:22];
  assign op8    = ir[31:24];
  assign op6    = ir[31:26];
  assign rd     = ir[4:0];
  assign rn     = ir[9:5];
  assign rm     = ir[20:16];
  assign pc_inc = pc_q + PC_WIDTH'(4);
  assign unused_flags = bus.status[3:1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      ir    <= '0;
      pc_q  <= RESET_PC;
    end else begin
      state <= state_nxt;
      ir    <= ir_nxt;
      pc_q  <= pc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ir_nxt    = ir;
    pc_nxt    = pc_q;
    cw        = '0;
    cst       = '0;
    halted    = 1'b0;
    unique case (state)
      FETCH: begin
        ir_nxt    = bus.instruction;
        state_nxt = EXEC;
      end
      EXEC: begin
        state_nxt = FETCH;
        pc_nxt    = pc_inc;
        // Longest opcode field first so shorter prefixes cannot shadow it.
        if (op11 == OP_ADD || op11 == OP_SUB || op11 == OP_AND || op11 == OP_ORR) begin
          cw.da     = rd;
          cw.sa     = rn;
          cw.sb     = rm;
          cw.rw     = 1'b1;
          cw.en_alu = 1'b1;
          cw.sl     = (op11 == OP_SUB);
          cw.fs     = (op11 == OP_SUB) ? FS_SUB :
                      (op11 == OP_AND) ? FS_AND :
                      (op11 == OP_ORR) ? FS_ORR : FS_ADD;
        end else if (op11 == OP_LDUR || op11 == OP_STUR) begin
          cw.sa      = rn;
          cw.bs      = 1'b1;
          cw.fs      = FS_ADD;
          cw.addr_en = 1'b1;
          cw.mem_cs  = 1'b1;
          cw.size    = 2'b11;
          cst        = sext_d9(ir[20:12]);
          if (op11 == OP_LDUR) begin
            cw.da     = rd;
            cw.rw     = 1'b1;
            cw.en_mem = 1'b1;
          end else begin
            cw.sb   = rd;
            cw.mw   = 1'b1;
            cw.en_b = 1'b1;
          end
        end else if (op10 == OP_ADDI || op10 == OP_SUBI) begin
          cw.da     = rd;
          cw.sa     = rn;
          cw.bs     = 1'b1;
          cw.rw     = 1'b1;
          cw.en_alu = 1'b1;
          cw.sl     = (op10 == OP_SUBI);
          cw.fs     = (op10 == OP_SUBI) ? FS_SUB : FS_ADD;
          cst       = {52'd0, ir[21:10]};
        end else if (op8 == OP_CBZ) begin
          cw.sa     = rd;
          cw.bs     = 1'b1;
          cw.fs     = FS_ADD;
          cw.sl     = 1'b1;
          pc_nxt    = pc_q;
          state_nxt = BRANCH;
        end else if (op6 == OP_B) begin
          pc_nxt = pc_q + $unsigned(off_imm26(ir[25:0]));
        end else begin
          pc_nxt    = pc_q;
          state_nxt = HALT;
        end
      end
      BRANCH: begin
        state_nxt = FETCH;
        pc_nxt    = bus.status[0] ? pc_q + $unsigned(off_imm19(ir[23:5])) : pc_inc;
      end
      HALT: begin
        halted = 1'b1;
      end
    endcase
  end

  assign bus.pc           = pc_q;
  assign bus.control_word = cw;
  assign bus.constant     = cst;
  assign bus.halted       = halted;

endmodule

// File: tb/tb_legv8_control_unit.sv
// Directed bench for legv8_control_unit: stimulus queues expected per-cycle outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_legv8_control_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] cw;
    logic [63:0] cst;
    logic        h;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] rom [16];
  exp_t        exp_q [$];
  string       name_q [$];
  exp_t        mon_e;
  string       mon_nm;
  int          total = 0;
  int          bad = 0;

  legv8_control_unit_if #(.PC_WIDTH(32)) bus ();

  legv8_control_unit #(.PC_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.instruction = rom[bus.pc[5:2]];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  // Monitor: outputs are compared mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e  = exp_q.pop_front();
      mon_nm = name_q.pop_front();
      chk({mon_nm, ".pc"},     {32'd0, bus.pc},           {32'd0, mon_e.pc});
      chk({mon_nm, ".cw"},     {32'd0, bus.control_word}, {32'd0, mon_e.cw});
      chk({mon_nm, ".const"},  bus.constant,              mon_e.cst);
      chk({mon_nm, ".halted"}, {63'd0, bus.halted},       {63'd0, mon_e.h});
    end
  end

  task automatic cyc(input string nm, input logic [31:0] p, input logic [31:0] c,
                     input logic [63:0] k, input logic h);
    exp_t e;
    e.pc = p; e.cw = c; e.cst = k; e.h = h;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk); #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 32'hFFFF_FFFF;
  endtask

  task automatic do_reset(input string nm);
    reset = 1'b0;
    cyc(nm, 32'h0, 32'h0, 64'h0, 1'b0);
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.status = 4'b0001;
    clear_rom();
    rom[0] = 32'h910063E0;  // ADDI X0,XZR,#24
    rom[1] = 32'hCB0003E1;  // SUB  X1,XZR,X0
    rom[2] = 32'hF80183E1;  // STUR X1,[XZR,#24]
    rom[3] = 32'hF84183E2;  // LDUR X2,[XZR,#24]
    rom[4] = 32'h14000004;  // B #+4 (0x10 -> 0x20)
    rom[6] = 32'h14000002;  // B #+2 (0x18 -> 0x20)
    rom[8] = 32'hB4FFFFC3;  // CBZ X3,#-2 (0x20 -> 0x18)
    @(posedge clk); #1;

    // Program A: ALU/memory decode, B, CBZ taken and not taken, halt.
    do_reset("a_reset");
    cyc("a_fetch_addi", 32'h00, 32'h0,         64'd0,  1'b0);
    cyc("a_exec_addi",  32'h00, 32'h011183E0,  64'd24, 1'b0);
    cyc("a_fetch_sub",  32'h04, 32'h0,         64'd0,  1'b0);
    cyc("a_exec_sub",   32'h04, 32'h015283E1,  64'd0,  1'b0);
    cyc("a_fetch_stur", 32'h08, 32'h0,         64'd0,  1'b0);
    cyc("a_exec_stur",  32'h08, 32'h3E9107E0,  64'd24, 1'b0);
    cyc("a_fetch_ldur", 32'h0C, 32'h0,         64'd0,  1'b0);
    cyc("a_exec_ldur",  32'h0C, 32'h5C9183E2,  64'd24, 1'b0);
    cyc("a_fetch_b",    32'h10, 32'h0,         64'd0,  1'b0);
    cyc("a_exec_b",     32'h10, 32'h0,         64'd0,  1'b0);
    cyc("a_fetch_cbz1", 32'h20, 32'h0,         64'd0,  1'b0);
    cyc("a_exec_cbz1",  32'h20, 32'h00510060,  64'd0,  1'b0);
    cyc("a_branch1",    32'h20, 32'h0,         64'd0,  1'b0);
    cyc("a_fetch_b2",   32'h18, 32'h0,         64'd0,  1'b0);
    cyc("a_exec_b2",    32'h18, 32'h0,         64'd0,  1'b0);
    cyc("a_fetch_cbz2", 32'h20, 32'h0,         64'd0,  1'b0);
    cyc("a_exec_cbz2",  32'h20, 32'h00510060,  64'd0,  1'b0);
    bus.status = 4'b0000;
    cyc("a_branch2",    32'h20, 32'h0,         64'd0,  1'b0);
    cyc("a_fetch_bad",  32'h24, 32'h0,         64'd0,  1'b0);
    cyc("a_exec_bad",   32'h24, 32'h0,         64'd0,  1'b0);
    for (int i = 0; i < 10; i++)
      cyc("a_halt",     32'h24, 32'h0,         64'd0,  1'b1);

    // Program B: remaining R-format ops, SUBI, asynchronous reset mid-EXEC.
    clear_rom();
    rom[0] = 32'h8B020023;  // ADD  X3,X1,X2
    rom[1] = 32'h8A020024;  // AND  X4,X1,X2
    rom[2] = 32'hAA020025;  // ORR  X5,X1,X2
    rom[3] = 32'hD1001426;  // SUBI X6,X1,#5
    rom[4] = 32'h8B020023;  // ADD  X3,X1,X2
    do_reset("b_reset_after_halt");
    cyc("b_fetch_add",  32'h00, 32'h0,         64'd0,  1'b0);
    cyc("b_exec_add",   32'h00, 32'h01108823,  64'd0,  1'b0);
    cyc("b_fetch_and",  32'h04, 32'h0,         64'd0,  1'b0);
    cyc("b_exec_and",   32'h04, 32'h01008824,  64'd0,  1'b0);
    cyc("b_fetch_orr",  32'h08, 32'h0,         64'd0,  1'b0);
    cyc("b_exec_orr",   32'h08, 32'h01088825,  64'd0,  1'b0);
    cyc("b_fetch_subi", 32'h0C, 32'h0,         64'd0,  1'b0);
    cyc("b_exec_subi",  32'h0C, 32'h01538026,  64'd5,  1'b0);
    cyc("b_fetch_add2", 32'h10, 32'h0,         64'd0,  1'b0);
    #2 reset = 1'b0;
    cyc("b_mid_exec_reset", 32'h00, 32'h0,     64'd0,  1'b0);
    reset = 1'b1;
    cyc("b_refetch",    32'h00, 32'h0,         64'd0,  1'b0);
    cyc("b_reexec_add", 32'h00, 32'h01108823,  64'd0,  1'b0);

    // Program C: backward B wraps below zero, forward B wraps past the top.
    clear_rom();
    rom[0]  = 32'h17FFFFFF; // B #-1 (0x0 -> 0xFFFFFFFC)
    rom[15] = 32'h14000002; // B #+2 (0xFFFFFFFC -> 0x4)
    do_reset("c_reset");
    cyc("c_fetch_bneg", 32'h00,        32'h0,  64'd0,  1'b0);
    cyc("c_exec_bneg",  32'h00,        32'h0,  64'd0,  1'b0);
    cyc("c_fetch_top",  32'hFFFFFFFC,  32'h0,  64'd0,  1'b0);
    cyc("c_exec_top",   32'hFFFFFFFC,  32'h0,  64'd0,  1'b0);
    cyc("c_fetch_wrap", 32'h04,        32'h0,  64'd0,  1'b0);
    cyc("c_exec_bad",   32'h04,        32'h0,  64'd0,  1'b0);
    cyc("c_halt",       32'h04,        32'h0,  64'd0,  1'b1);

    @(negedge clk); #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
